// File: rtl/countdown_timer.sv
// Loadable seconds countdown for the per-round time limit; steps on divider ticks,
// reports the remaining time as two BCD digits, plus a done pulse and an expired level.
module countdown_timer #(
  parameter int MAX_COUNT = 99,
  parameter int COUNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_in,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               start,
  input  logic               pause,
  output logic               tick_en,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic               running,
  output logic               done,
  output logic               expired
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] ONE_C = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] TEN_C = COUNT_W'(10);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tick_en_q, tick_en_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               expired_q, expired_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = (count_q != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          // pause wins over a coincident tick, which is dropped
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_in) begin
            if (count_q > ONE_C) begin
              count_d = count_q - ONE_C;
            end else begin
              count_d = '0;
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        ST_DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end

    // outputs registered from the next state so they move with the state edge
    tick_en_d = (state_d == ST_RUN);
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_DONE);
    done_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      tick_en_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_en_q <= tick_en_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign tick_en  = tick_en_q;
  assign running  = running_q;
  assign done     = done_q;
  assign expired  = expired_q;
  assign bcd_tens = 4'(count_q / TEN_C);
  assign bcd_ones = 4'(count_q % TEN_C);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: per-cycle comparison against a mode/seconds model,
// plus literal expectations along the directed scenarios.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_value = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick_en, running, done, expired;
  logic [3:0] bcd_tens, bcd_ones;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  countdown_timer dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick_en(tick_en), .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: mode 0 idle, 1 counting, 2 paused, 3 expired; seconds left as an int.
  int m_mode = 0;
  int m_secs = 0;
  bit m_done = 1'b0;

  always @(posedge clk) begin
    int prev;
    prev = m_mode;
    if (!rst) begin
      m_mode = 0; m_secs = 0; m_done = 1'b0;
    end else begin
      if (load) begin
        m_secs = (load_value > 99) ? 99 : int'(load_value);
        m_mode = 0;
      end else if (m_mode == 0 && start) m_mode = (m_secs > 0) ? 1 : 3;
      else if (m_mode == 1 && pause) m_mode = 2;
      else if (m_mode == 2 && start) m_mode = 1;
      else if (m_mode == 1 && tick_in) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) m_mode = 3;
      end
      m_done = (m_mode == 3) && (prev != 3);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model",
          {20'd0, tick_en, running, done, expired, bcd_tens, bcd_ones},
          {20'd0, m_mode == 1, m_mode == 1, m_done, m_mode == 3,
           4'(m_secs / 10), 4'(m_secs % 10)});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = 7'(v); step(1); load = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask
  task automatic do_tick();
    tick_in = 1'b1; step(1); tick_in = 1'b0;
  endtask

  function automatic logic [31:0] bcd();
    return {24'd0, bcd_tens, bcd_ones};
  endfunction

  initial begin
    // reset
    rst = 1'b0; step(2);
    armed = 1'b1;
    chk("reset_bcd", bcd(), 32'h00);
    chk("reset_flags", {28'd0, tick_en, running, done, expired}, 32'h0);
    rst = 1'b1; step(1);

    // basic countdown from 5
    do_load(5);
    chk("load5", bcd(), 32'h05);
    do_start();
    chk("run_tick_en", {31'd0, tick_en}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      chk("basic_ones", {28'd0, bcd_ones}, 32'(4 - i));
      chk("basic_done", {31'd0, done}, (i == 4) ? 32'h1 : 32'h0);
      step(3);
    end
    chk("basic_after", {29'd0, done, expired, tick_en}, 32'b010);

    // saturation and decode
    do_load(120);
    chk("sat120", bcd(), 32'h99);
    do_load(47);
    chk("load47", bcd(), 32'h47);
    do_start();
    do_tick();
    chk("tick46", bcd(), 32'h46);

    // pause / resume
    do_load(10);
    do_start();
    for (int i = 0; i < 3; i++) begin
      do_tick(); step(1);
    end
    chk("run7", bcd(), 32'h07);
    pause = 1'b1; tick_in = 1'b1; step(1); pause = 1'b0; tick_in = 1'b0;
    chk("pause_hold", bcd(), 32'h07);
    chk("pause_tick_en", {31'd0, tick_en}, 32'h0);
    do_tick(); do_tick();
    chk("paused_ticks", bcd(), 32'h07);
    do_start();
    chk("resume_no_dec", bcd(), 32'h07);
    do_tick();
    chk("resume_tick", bcd(), 32'h06);

    // zero load and ignored inputs in DONE
    do_load(0);
    do_start();
    chk("zero_done", {30'd0, done, expired}, 32'b11);
    step(1);
    chk("zero_done_once", {30'd0, done, expired}, 32'b01);
    do_start(); do_tick();
    pause = 1'b1; step(1); pause = 1'b0;
    chk("done_ignore", {24'd0, bcd_tens, bcd_ones} | {29'd0, done, tick_en, 1'b0}, 32'h0);
    chk("done_stays", {31'd0, expired}, 32'h1);
    do_load(3);
    chk("reload3", {23'd0, expired, bcd_tens, bcd_ones}, 32'h003);

    // held tick must stop at zero
    do_start();
    tick_in = 1'b1; step(6); tick_in = 1'b0;
    chk("held_tick", {23'd0, expired, bcd_tens, bcd_ones}, 32'h100);

    // abort by load, then reset mid-run
    do_load(8);
    do_start();
    do_tick(); do_tick();
    chk("abort_pre", bcd(), 32'h06);
    do_load(4);
    chk("abort_load", {21'd0, running, done, expired, bcd_tens, bcd_ones}, 32'h004);
    do_start();
    do_tick();
    chk("abort_run3", bcd(), 32'h03);
    rst = 1'b0; step(1);
    chk("midrun_reset", {23'd0, tick_en, bcd_tens, bcd_ones}, 32'h000);
    step(1);
    rst = 1'b1; step(2);
    chk("post_reset_idle", {30'd0, running, expired}, 32'h0);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
